// File: rtl/edge_to_level_if.sv
// Request/level bundle for edge_to_level: event pulses in, reconstructed level and status out.
// The master drives the event requests; the slave (the reconstructor) drives everything else.
interface edge_to_level_if;
  logic p_edge;
  logic n_edge;
  logic tgl;
  logic level;
  logic rise_o;
  logic fall_o;
  logic busy;
  logic err_dup;
  logic err_sim;

  modport master (
    output p_edge, n_edge, tgl,
    input  level, rise_o, fall_o, busy, err_dup, err_sim
  );

  modport slave (
    input  p_edge, n_edge, tgl,
    output level, rise_o, fall_o, busy, err_dup, err_sim
  );
endinterface

// File: rtl/edge_to_level.sv
// Rebuilds a level from rise/fall/toggle event pulses, holding early edges until the min dwell is met.
// Unconstrained edge reaches level one cycle later; there is no backpressure, extra requests are flagged.
module edge_to_level #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CNT_W    = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  edge_to_level_if.slave bus
);

  if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
    $error("edge_to_level: CNT_W out of range");
  end
  if (MIN_HIGH < 1 || MIN_HIGH > (1 << CNT_W) - 1) begin : g_bad_min_high
    $error("edge_to_level: MIN_HIGH out of range");
  end
  if (MIN_LOW < 1 || MIN_LOW > (1 << CNT_W) - 1) begin : g_bad_min_low
    $error("edge_to_level: MIN_LOW out of range");
  end

  localparam logic [CNT_W-1:0] MIN_H = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LOW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    HIGH   = 2'd1,
    PEND_R = 2'd2,
    PEND_F = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;
  logic             dup_q;
  logic             sim_q;

  logic             multi;
  logic             target;
  logic             rise_req;
  logic             fall_req;
  logic             dup_nx;
  logic             level_nx;

  always_comb begin
    multi    = (bus.p_edge & bus.n_edge) | (bus.p_edge & bus.tgl) | (bus.n_edge & bus.tgl);
    target   = (state == HIGH) || (state == PEND_R);
    rise_req = ~multi & (bus.p_edge | (bus.tgl & ~target));
    fall_req = ~multi & (bus.n_edge | (bus.tgl &  target));
    state_nx = state;
    dup_nx   = 1'b0;
    case (state)
      LOW: begin
        if (rise_req)      state_nx = (cnt >= MIN_L) ? HIGH : PEND_R;
        else if (fall_req) dup_nx   = 1'b1;
      end
      HIGH: begin
        if (fall_req)      state_nx = (cnt >= MIN_H) ? LOW : PEND_F;
        else if (rise_req) dup_nx   = 1'b1;
      end
      PEND_R: begin
        // A cancelling request wins over a dwell that expires in the same cycle.
        if (fall_req) begin
          state_nx = LOW;
        end else begin
          dup_nx = rise_req;
          if (cnt >= MIN_L) state_nx = HIGH;
        end
      end
      PEND_F: begin
        if (rise_req) begin
          state_nx = HIGH;
        end else begin
          dup_nx = fall_req;
          if (cnt >= MIN_H) state_nx = LOW;
        end
      end
      default: state_nx = LOW;
    endcase
    level_nx = (state_nx == HIGH) || (state_nx == PEND_F);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LOW;
      cnt     <= CNT_MAX;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      dup_q   <= 1'b0;
      sim_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      level_q <= level_nx;
      rise_q  <= level_nx & ~level_q;
      fall_q  <= ~level_nx & level_q;
      busy_q  <= (state_nx == PEND_R) || (state_nx == PEND_F);
      dup_q   <= dup_nx;
      sim_q   <= multi;
      if (level_nx != level_q)  cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;
    end
  end

  assign bus.level   = level_q;
  assign bus.rise_o  = rise_q;
  assign bus.fall_o  = fall_q;
  assign bus.busy    = busy_q;
  assign bus.err_dup = dup_q;
  assign bus.err_sim = sim_q;

endmodule

// File: tb/tb_edge_to_level.sv
// Scoreboard bench for edge_to_level: directed dwell/cancel/error sequences plus a random round trip.
module tb_edge_to_level;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  edge_to_level_if bus0();
  edge_to_level_if bus1();

  edge_to_level #(.MIN_HIGH(4), .MIN_LOW(4), .CNT_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave)
  );
  edge_to_level #(.MIN_HIGH(1), .MIN_LOW(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
  );

  int compared = 0;
  int mismatched = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs0();
    return {bus0.level, bus0.rise_o, bus0.fall_o, bus0.busy, bus0.err_dup, bus0.err_sim};
  endfunction

  function automatic logic [5:0] outs1();
    return {bus1.level, bus1.rise_o, bus1.fall_o, bus1.busy, bus1.err_dup, bus1.err_sim};
  endfunction

  // {p_edge, n_edge, tgl} driven in cycle c of test tid
  function automatic logic [2:0] stim(input int tid, input int c);
    logic p, n, t;
    p = 1'b0; n = 1'b0; t = 1'b0;
    case (tid)
      1: begin p = (c == 5); n = (c == 12); end
      2: begin p = (c == 0); n = (c == 1); end
      3: begin p = (c == 0) || (c == 2); n = (c == 1); end
      4: begin p = (c == 0) || (c == 3) || (c == 6); n = (c == 6) || (c == 9) || (c == 12); end
      5: t = (c == 0) || (c == 10) || (c == 20);
      6: p = (c == 0);
      7: begin p = (c == 0) || (c == 7); n = (c == 5); end
      default: ;
    endcase
    return {p, n, t};
  endfunction

  // {level, rise_o, fall_o, busy, err_dup, err_sim} expected in cycle c of test tid
  function automatic logic [5:0] expv(input int tid, input int c);
    logic l, r, f, b, d, s;
    l = 1'b0; r = 1'b0; f = 1'b0; b = 1'b0; d = 1'b0; s = 1'b0;
    case (tid)
      1: begin l = (c >= 6 && c <= 12); r = (c == 6); f = (c == 13); end
      2: begin l = (c >= 1 && c <= 4); r = (c == 1); f = (c == 5); b = (c >= 2 && c <= 4); end
      3: begin l = (c >= 1); r = (c == 1); b = (c == 2); end
      4: begin
        l = (c >= 1 && c <= 9); r = (c == 1); f = (c == 10);
        d = (c == 4) || (c == 13); s = (c == 7);
      end
      5: begin
        l = (c >= 1 && c <= 10) || (c >= 21); r = (c == 1) || (c == 21); f = (c == 11);
      end
      6: begin l = (c >= 1); r = (c == 1); end
      7: begin
        l = (c >= 1 && c <= 5) || (c >= 10); r = (c == 1) || (c == 10); f = (c == 6);
        b = (c == 8) || (c == 9);
      end
      default: ;
    endcase
    return {l, r, f, b, d, s};
  endfunction

  task automatic drive0(input logic [2:0] v);
    bus0.p_edge = v[2];
    bus0.n_edge = v[1];
    bus0.tgl    = v[0];
  endtask

  task automatic do_reset();
    drive0(3'b000);
    bus1.p_edge = 1'b0;
    bus1.n_edge = 1'b0;
    bus1.tgl    = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Runs cycles 0..ncyc of a directed test starting at the current negedge.
  task automatic run_seq(input int tid, input int ncyc);
    exp_q.push_back(expv(tid, 0));
    for (int c = 0; c < ncyc; c++) begin
      check($sformatf("t%0d_c%0d", tid, c), 32'(outs0()), 32'(exp_q.pop_front()));
      drive0(stim(tid, c));
      exp_q.push_back(expv(tid, c + 1));
      @(negedge clk);
    end
    check($sformatf("t%0d_c%0d", tid, ncyc), 32'(outs0()), 32'(exp_q.pop_front()));
    drive0(3'b000);
  endtask

  initial begin
    logic lvl, prev;
    drive0(3'b000);
    bus1.p_edge = 1'b0;
    bus1.n_edge = 1'b0;
    bus1.tgl    = 1'b0;

    do_reset(); run_seq(1, 16);
    do_reset(); run_seq(2, 8);
    do_reset(); run_seq(3, 10);
    do_reset(); run_seq(4, 15);
    do_reset(); run_seq(5, 24);
    do_reset(); run_seq(7, 14);

    // Reset arriving mid-cycle while an edge is pending must clear outputs without a clock.
    do_reset(); run_seq(2, 3);
    #2 reset_n = 1'b0;
    exp_q.push_back(6'b000000);
    #1 check("async_rst_pend", 32'(outs0()), 32'(exp_q.pop_front()));
    @(negedge clk);
    reset_n = 1'b1;
    run_seq(6, 5);

    // Round trip: random level -> edge detector -> MIN=1 instance tracks it one cycle later.
    do_reset();
    prev = 1'b0;
    exp_q.push_back(6'b000000);
    for (int c = 0; c < 200; c++) begin
      check($sformatf("rt_c%0d", c), 32'(outs1()), 32'(exp_q.pop_front()));
      lvl = 1'($urandom_range(0, 1));
      bus1.p_edge = lvl & ~prev;
      bus1.n_edge = ~lvl & prev;
      exp_q.push_back({lvl, lvl & ~prev, ~lvl & prev, 3'b000});
      prev = lvl;
      @(negedge clk);
    end
    check("rt_last", 32'(outs1()), 32'(exp_q.pop_front()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
